carrier_nbits_ncarr: RTL and testbench



---
 rtl/carrier_nbits_ncarr_pkg.sv | 7 +
 rtl/carrier_nbits_ncarr_channel.sv | 40 ++++
 rtl/carrier_nbits_ncarr.sv | 73 +++++++
 tb/tb_carrier_nbits_ncarr.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/carrier_nbits_ncarr_pkg.sv
// carrier_nbits_ncarr_pkg: count/mask mode enums and default widths for the multi-carrier generator
package carrier_nbits_ncarr_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int EVT_WIDTH_DEF = 4;
  typedef enum logic [1:0] {CM_UP = 2'b00, CM_DOWN = 2'b01, CM_UPDOWN = 2'b10, CM_UP_ALT = 2'b11} count_mode_t;
  typedef enum logic [1:0] {MM_MIN = 2'b00, MM_MAX = 2'b01, MM_BOTH = 2'b10, MM_NONE = 2'b11} mask_mode_t;
endpackage

// File: rtl/carrier_nbits_ncarr_channel.sv
// carrier_nbits_ncarr_channel: one carrier counter (c) with direction flag (dir), idle-loads clamped init/init_dir, counts per mode while run
module carrier_nbits_ncarr_channel
  import carrier_nbits_ncarr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] init,
  input  logic             init_dir,
  input  count_mode_t      mode,
  output logic [WIDTH-1:0] c,
  output logic             dir
);
  logic [WIDTH-1:0] c_nxt;
  logic dir_nxt, at_top, at_bot;
  assign at_top = c >= period;
  assign at_bot = c == '0;
  always_comb begin
    c_nxt = init > period ? period : init;
    dir_nxt = mode == CM_UPDOWN ? init_dir : mode == CM_DOWN;
    if (run && mode == CM_UPDOWN) begin
      dir_nxt = dir ? !at_bot : at_top;
      c_nxt = dir_nxt ? c - WIDTH'(!at_bot) : c + WIDTH'(period != '0);
    end else if (run) begin
      c_nxt = mode == CM_DOWN ? (at_bot ? period : c - 1'b1) : (c == period ? '0 : c + 1'b1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      c <= '0;
      dir <= 1'b0;
    end else begin
      c <= c_nxt;
      dir <= dir_nxt;
    end
  end
endmodule

// File: rtl/carrier_nbits_ncarr.sv
// carrier_nbits_ncarr: NCARR shadowed carriers (carrier/carrier_dir) with carrier-0 event decode, decimated maskevent and irq pulse
module carrier_nbits_ncarr
  import carrier_nbits_ncarr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCARR = 4,
  parameter int EVT_WIDTH = EVT_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       period,
  input  logic [NCARR*WIDTH-1:0] initcarr,
  input  logic [NCARR-1:0]       initdir,
  input  logic [EVT_WIDTH-1:0]   eventcount,
  input  logic [1:0]             countmode,
  input  logic [1:0]             maskmode,
  input  logic                   pwm_onoff,
  input  logic                   int_onoff,
  output logic [NCARR*WIDTH-1:0] carrier,
  output logic [NCARR-1:0]       carrier_dir,
  output logic                   maskevent,
  output logic                   irq
);
  logic [WIDTH-1:0] period_s, c0;
  logic [NCARR*WIDTH-1:0] initcarr_s;
  logic [NCARR-1:0] initdir_s;
  logic [EVT_WIDTH-1:0] eventcount_s, evt_cnt;
  count_mode_t countmode_s;
  mask_mode_t maskmode_s;
  logic single, run;
  assign run = pwm_onoff && !reset;
  assign c0 = carrier[WIDTH-1:0];
  assign single = run && (maskmode_s == MM_MIN ? c0 == '0 :
                          maskmode_s == MM_MAX ? c0 == period_s :
                          maskmode_s == MM_BOTH && (c0 == '0 || c0 == period_s));
  assign maskevent = single && evt_cnt == eventcount_s;
  always_ff @(posedge clk) begin
    if (reset) begin
      period_s <= '0;
      initcarr_s <= '0;
      initdir_s <= '0;
      eventcount_s <= '0;
      countmode_s <= CM_UP;
      maskmode_s <= MM_MIN;
      evt_cnt <= '0;
      irq <= 1'b0;
    end else begin
      if (!pwm_onoff || maskevent) begin
        period_s <= period;
        initcarr_s <= initcarr;
        initdir_s <= initdir;
        eventcount_s <= eventcount;
        countmode_s <= count_mode_t'(countmode);
        maskmode_s <= mask_mode_t'(maskmode);
      end
      evt_cnt <= !pwm_onoff ? '0 : single ? (maskevent ? '0 : evt_cnt + 1'b1) : evt_cnt;
      irq <= maskevent && int_onoff;
    end
  end
  for (genvar i = 0; i < NCARR; i++) begin : g_ch
    carrier_nbits_ncarr_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .run     (pwm_onoff),
      .period  (period_s),
      .init    (initcarr_s[i*WIDTH +: WIDTH]),
      .init_dir(initdir_s[i]),
      .mode    (countmode_s),
      .c       (carrier[i*WIDTH +: WIDTH]),
      .dir     (carrier_dir[i])
    );
  end
endmodule

// File: tb/tb_carrier_nbits_ncarr.sv
// tb_carrier_nbits_ncarr: scoreboard bench for carrier_nbits_ncarr (WIDTH=16, NCARR=4, EVT_WIDTH=4)
module tb_carrier_nbits_ncarr;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] period = '0;
  logic [63:0] initcarr = '0;
  logic [3:0] initdir = '0, eventcount = '0;
  logic [1:0] countmode = '0, maskmode = '0;
  logic pwm_onoff = 1'b0, int_onoff = 1'b0;
  logic [63:0] carrier;
  logic [3:0] carrier_dir;
  logic maskevent, irq;
  carrier_nbits_ncarr #(.WIDTH(16), .NCARR(4), .EVT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .period(period), .initcarr(initcarr), .initdir(initdir),
    .eventcount(eventcount), .countmode(countmode), .maskmode(maskmode),
    .pwm_onoff(pwm_onoff), .int_onoff(int_onoff), .carrier(carrier),
    .carrier_dir(carrier_dir), .maskevent(maskevent), .irq(irq)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [63:0] c;
    logic [3:0] d;
    logic m;
    logic i;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] mc[4];
  logic [3:0] md, sd, se, cnt;
  logic [15:0] sp;
  logic [63:0] si;
  logic [1:0] scm, smm;
  logic mirq;
  function automatic logic m_single();
    logic z, t;
    z = mc[0] == 16'd0;
    t = mc[0] == sp;
    return pwm_onoff && !reset && (smm == 2'd0 ? z : smm == 2'd1 ? t : smm == 2'd2 ? (z || t) : 1'b0);
  endfunction
  task automatic step();
    logic sg, me;
    logic [15:0] c, lo;
    sg = m_single();
    me = sg && cnt == se;
    if (reset) begin
      for (int i = 0; i < 4; i++) mc[i] = 16'd0;
      md = '0; sp = '0; si = '0; sd = '0; se = '0; scm = '0; smm = '0; cnt = '0; mirq = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        c = mc[i];
        if (!pwm_onoff) begin
          lo = si[i*16 +: 16];
          mc[i] = lo > sp ? sp : lo;
          md[i] = scm == 2'd2 ? sd[i] : scm == 2'd1;
        end else if (scm == 2'd2) begin
          if (!md[i]) begin
            if (c == sp) begin md[i] = 1'b1; mc[i] = sp == 16'd0 ? 16'd0 : c - 16'd1; end
            else mc[i] = c + 16'd1;
          end else begin
            if (c == 16'd0) begin md[i] = 1'b0; mc[i] = sp == 16'd0 ? 16'd0 : 16'd1; end
            else mc[i] = c - 16'd1;
          end
        end else if (scm == 2'd1) begin
          md[i] = 1'b1;
          mc[i] = c == 16'd0 ? sp : c - 16'd1;
        end else begin
          md[i] = 1'b0;
          mc[i] = c == sp ? 16'd0 : c + 16'd1;
        end
      end
      cnt = !pwm_onoff ? 4'd0 : sg ? (me ? 4'd0 : cnt + 4'd1) : cnt;
      mirq = me && int_onoff;
      if (!pwm_onoff || me) begin
        sp = period; si = initcarr; sd = initdir; se = eventcount; scm = countmode; smm = maskmode;
      end
    end
    q.push_back({mc[3], mc[2], mc[1], mc[0], md, m_single() && cnt == se, mirq});
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL reset_sb cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      pwm_onoff = 1'b1;
    end
    n_cmp++;
    if ({carrier, carrier_dir, maskevent, irq} !== 70'd0) begin n_bad++; $display("FAIL reset_zero got=%h exp=0", {carrier, carrier_dir, maskevent, irq}); end
  endtask
  task automatic test_up();
    int nev = 0;
    reset = 1'b0; pwm_onoff = 1'b0; period = 16'd9; initcarr = {16'd9, 16'd5, 16'd2, 16'd0};
    countmode = 2'd0; maskmode = 2'd0; eventcount = 4'd0; int_onoff = 1'b0;
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL up_idle cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
    n_cmp++;
    if (carrier[63:48] !== 16'd9 || carrier[31:16] !== 16'd2) begin n_bad++; $display("FAIL up_idle_init got c3=%0d c1=%0d exp 9 2", carrier[63:48], carrier[31:16]); end
    pwm_onoff = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL up_run cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      if (k == 0) begin
        n_cmp++;
        if (carrier[63:48] !== 16'd0 || carrier[15:0] !== 16'd1) begin n_bad++; $display("FAIL up_first got c3=%0d c0=%0d exp 0 1", carrier[63:48], carrier[15:0]); end
      end
      nev += int'(maskevent);
    end
    n_cmp++;
    if (nev != 2) begin n_bad++; $display("FAIL up_evt_count got=%0d exp=2", nev); end
  endtask
  task automatic test_updown();
    int seq[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};
    pwm_onoff = 1'b0; period = 16'd4; initcarr = '0; initdir = 4'd0; countmode = 2'd2; maskmode = 2'd2; eventcount = 4'd0;
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL ud_idle cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
    pwm_onoff = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL ud_run cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      n_cmp++;
      if (int'(carrier[15:0]) != seq[k]) begin n_bad++; $display("FAIL ud_seq k=%0d got=%0d exp=%0d", k, carrier[15:0], seq[k]); end
    end
    eventcount = 4'd2;
    repeat (24) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL ud_decim cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
  endtask
  task automatic test_period_change();
    logic [15:0] mx = '0;
    pwm_onoff = 1'b0; period = 16'd9; initcarr = '0; countmode = 2'd0; maskmode = 2'd0; eventcount = 4'd0;
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL pc_idle cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
    pwm_onoff = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 4) period = 16'd5;
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL pc_run cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      if (k >= 14 && carrier[15:0] > mx) mx = carrier[15:0];
    end
    n_cmp++;
    if (mx !== 16'd5) begin n_bad++; $display("FAIL pc_new_peak got=%0d exp=5", mx); end
  endtask
  task automatic test_irq();
    int nirq = 0, nadj = 0;
    logic prev = 1'b0;
    int_onoff = 1'b1;
    repeat (12) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL irq_on cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      nirq += int'(irq);
      nadj += int'(irq && prev);
      prev = irq;
    end
    n_cmp++;
    if (nirq != 2 || nadj != 0) begin n_bad++; $display("FAIL irq_pulses got=%0d/%0d exp=2/0", nirq, nadj); end
    int_onoff = 1'b0;
    nirq = 0;
    repeat (12) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL irq_off cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      nirq += int'(irq);
    end
    n_cmp++;
    if (nirq != 0) begin n_bad++; $display("FAIL irq_disabled got=%0d exp=0", nirq); end
  endtask
  task automatic test_edges();
    pwm_onoff = 1'b0; period = 16'd0; maskmode = 2'd0; countmode = 2'd0; initcarr = {16'd3, 16'd3, 16'd3, 16'd3};
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL p0_idle cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
    pwm_onoff = 1'b1;
    repeat (5) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL p0_run cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      n_cmp++;
      if (carrier !== 64'd0 || maskevent !== 1'b1) begin n_bad++; $display("FAIL p0_const got c=%h m=%b exp c=0 m=1", carrier, maskevent); end
    end
    pwm_onoff = 1'b0; period = 16'd9; initcarr = {16'd0, 16'd0, 16'd0, 16'd20}; countmode = 2'd3;
    repeat (2) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL clamp_idle cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
    end
    n_cmp++;
    if (carrier[15:0] !== 16'd9) begin n_bad++; $display("FAIL clamp got=%0d exp=9", carrier[15:0]); end
    pwm_onoff = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL mode11 cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      if (k == 1) begin
        n_cmp++;
        if (carrier[15:0] !== 16'd1 || carrier_dir !== 4'd0) begin n_bad++; $display("FAIL mode11_up got c0=%0d d=%b exp 1 0000", carrier[15:0], carrier_dir); end
      end
    end
  endtask
  task automatic test_reset_midrun();
    reset = 1'b1;
    step(); e = q.pop_front(); n_cmp++;
    if ({carrier, carrier_dir, maskevent, irq} !== 70'd0) begin n_bad++; $display("FAIL rst_mid got=%h exp=0", {carrier, carrier_dir, maskevent, irq}); end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(); e = q.pop_front(); n_cmp++;
      if ({carrier, carrier_dir, maskevent, irq} !== e) begin n_bad++; $display("FAIL rst_release cyc=%0d got=%h exp=%h", cyc, {carrier, carrier_dir, maskevent, irq}, e); end
      if (k == 1) begin
        n_cmp++;
        if (carrier[15:0] !== 16'd1 || carrier[63:48] !== 16'd1) begin n_bad++; $display("FAIL rst_restart got c0=%0d c3=%0d exp 1 1", carrier[15:0], carrier[63:48]); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_up();
    test_updown();
    test_period_change();
    test_irq();
    test_edges();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
